// File: rtl/sfifo_flags_if.sv
// Handshake/status bundle for sfifo_flags: producer/consumer controls in, data and flags out.
interface sfifo_flags_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ABITS = 4
);
    logic             clear_i;
    logic             wr_en_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             wfull_o;
    logic             rempty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [ABITS:0]   level_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output clear_i, wr_en_i, wr_data_i, rd_en_i,
        input  rd_data_o, wfull_o, rempty_o, almost_full_o, almost_empty_o,
               level_o, overflow_o, underflow_o
    );

    modport slave (
        input  clear_i, wr_en_i, wr_data_i, rd_en_i,
        output rd_data_o, wfull_o, rempty_o, almost_full_o, almost_empty_o,
               level_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sfifo_flags.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow and synchronous flush.
module sfifo_flags #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ABITS  = 4,
    parameter int unsigned AFULL  = 12,
    parameter int unsigned AEMPTY = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    sfifo_flags_if.slave fif
);
    localparam int unsigned    DEPTH    = 1 << ABITS;
    localparam logic [ABITS:0] DEPTH_L  = (ABITS + 1)'(DEPTH);
    localparam logic [ABITS:0] AFULL_L  = (ABITS + 1)'(AFULL);
    localparam logic [ABITS:0] AEMPTY_L = (ABITS + 1)'(AEMPTY);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ABITS-1:0] wptr;
    logic [ABITS-1:0] rptr;
    logic [ABITS:0]   level;
    logic [WIDTH-1:0] rd_data;
    logic             overflow;
    logic             underflow;

    logic full;
    logic empty;
    logic wr_ok;
    logic rd_ok;

    // Full/empty come from the registered level only, so same-cycle ops never
    // affect acceptance at this edge.
    always_comb begin
        full  = (level == DEPTH_L);
        empty = (level == '0);
        wr_ok = fif.wr_en_i && !full;
        rd_ok = fif.rd_en_i && !empty;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && !fif.clear_i && wr_ok) begin
            mem[wptr] <= fif.wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (fif.clear_i) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + 1'b1;
            end
            if (fif.wr_en_i && full) begin
                overflow <= 1'b1;
            end
            if (fif.rd_en_i && empty) begin
                underflow <= 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        fif.rd_data_o      = rd_data;
        fif.level_o        = level;
        fif.wfull_o        = full;
        fif.rempty_o       = empty;
        fif.almost_full_o  = (level >= AFULL_L);
        fif.almost_empty_o = (level <= AEMPTY_L);
        fif.overflow_o     = overflow;
        fif.underflow_o    = underflow;
    end
endmodule

// File: tb/tb_sfifo_flags.sv
// Self-checking bench for sfifo_flags: directed table, corner sequences and random
// traffic against a queue-based reference model.
module tb_sfifo_flags;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned AE    = 2;

    logic clk;
    logic reset;

    sfifo_flags_if #(.WIDTH(16), .ABITS(4)) fif ();

    sfifo_flags #(
        .WIDTH (16),
        .ABITS (4),
        .AFULL (AF),
        .AEMPTY(AE)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .fif    (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] m_rdd = '0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    typedef struct {
        logic        rst;
        logic        clr;
        logic        wr;
        logic        rd;
        logic [15:0] wd;
        int unsigned lvl;
        logic [15:0] rdd;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[12];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic clr, input logic wr,
                              input logic [15:0] wd, input logic rd);
        bit was_full;
        bit was_empty;
        if (rst) begin
            mq.delete();
            m_rdd = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (rd) begin
                if (was_empty) m_unf = 1'b1;
                else           m_rdd = mq.pop_front();
            end
            if (wr) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back(wd);
            end
        end
    endtask

    task automatic check_model(input string tag);
        int unsigned n;
        n = mq.size();
        cmp({tag, ".level"},   32'(fif.level_o),        32'(n));
        cmp({tag, ".full"},    32'(fif.wfull_o),        32'(n == DEPTH));
        cmp({tag, ".empty"},   32'(fif.rempty_o),       32'(n == 0));
        cmp({tag, ".afull"},   32'(fif.almost_full_o),  32'(n >= AF));
        cmp({tag, ".aempty"},  32'(fif.almost_empty_o), 32'(n <= AE));
        cmp({tag, ".ovf"},     32'(fif.overflow_o),     32'(m_ovf));
        cmp({tag, ".unf"},     32'(fif.underflow_o),    32'(m_unf));
        cmp({tag, ".rd_data"}, 32'(fif.rd_data_o),      32'(m_rdd));
    endtask

    // Drive one cycle, advance the model across the edge, then check 1ns after it.
    task automatic apply(input logic rst, input logic clr, input logic wr,
                         input logic [15:0] wd, input logic rd, input string tag);
        reset         = rst;
        fif.clear_i   = clr;
        fif.wr_en_i   = wr;
        fif.wr_data_i = wd;
        fif.rd_en_i   = rd;
        @(posedge clk);
        model_edge(rst, clr, wr, wd, rd);
        #1;
        check_model(tag);
    endtask

    initial begin
        reset         = 1'b1;
        fif.clear_i   = 1'b0;
        fif.wr_en_i   = 1'b0;
        fif.wr_data_i = '0;
        fif.rd_en_i   = 1'b0;

        //            rst   clr   wr    rd    wd        lvl rdd       ovf   unf
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h00AA, 1, 16'h0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1111, 2, 16'h0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 16'h00AA, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h1111, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h1111, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h2222, 0, 16'h1111, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h3333, 1, 16'h1111, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h4444, 2, 16'h1111, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 2, 16'h3333, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h6666, 0, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].rst, tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd, $sformatf("tbl%0d", i));
            cmp($sformatf("tbl%0d.lvl", i), 32'(fif.level_o),     32'(tbl[i].lvl));
            cmp($sformatf("tbl%0d.rdd", i), 32'(fif.rd_data_o),   32'(tbl[i].rdd));
            cmp($sformatf("tbl%0d.ovf", i), 32'(fif.overflow_o),  32'(tbl[i].ovf));
            cmp($sformatf("tbl%0d.unf", i), 32'(fif.underflow_o), 32'(tbl[i].unf));
        end

        // Fill 0x0001..0x0010
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, "fill_rst");
        for (int k = 1; k <= 16; k++) begin
            apply(1'b0, 1'b0, 1'b1, 16'(k), 1'b0, "fill");
            cmp("fill.lvl",   32'(fif.level_o),       32'(k));
            cmp("fill.afull", 32'(fif.almost_full_o), 32'(k >= 12));
        end
        cmp("fill.full", 32'(fif.wfull_o), 32'd1);

        // Overflow, then full + rd + wr
        apply(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, "ovf");
        cmp("ovf.flag", 32'(fif.overflow_o), 32'd1);
        cmp("ovf.lvl",  32'(fif.level_o),    32'd16);
        apply(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, "full_rw");
        cmp("full_rw.lvl", 32'(fif.level_o),   32'd15);
        cmp("full_rw.rdd", 32'(fif.rd_data_o), 32'h0001);

        for (int k = 2; k <= 16; k++) begin
            apply(1'b0, 1'b0, 1'b0, '0, 1'b1, "drain");
            cmp("drain.rdd", 32'(fif.rd_data_o), 32'(k));
        end
        cmp("drain.empty", 32'(fif.rempty_o), 32'd1);

        // Underflow, then empty + rd + wr
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, "unf");
        cmp("unf.rdd",  32'(fif.rd_data_o),   32'h0010);
        cmp("unf.flag", 32'(fif.underflow_o), 32'd1);
        apply(1'b0, 1'b0, 1'b1, 16'h00AA, 1'b1, "empty_rw");
        cmp("empty_rw.lvl", 32'(fif.level_o), 32'd1);
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, "empty_rw_rd");
        cmp("empty_rw_rd.rdd", 32'(fif.rd_data_o), 32'h00AA);

        // Clear at level 5 with both error flags set
        for (int k = 0; k < 5; k++) apply(1'b0, 1'b0, 1'b1, 16'(16'h0A00 + k), 1'b0, "pre_clr");
        cmp("pre_clr.ovf", 32'(fif.overflow_o), 32'd1);
        apply(1'b0, 1'b1, 1'b0, '0, 1'b0, "clr");
        cmp("clr.lvl", 32'(fif.level_o),    32'd0);
        cmp("clr.rdd", 32'(fif.rd_data_o),  32'h00AA);
        cmp("clr.ovf", 32'(fif.overflow_o), 32'd0);
        apply(1'b1, 1'b1, 1'b0, '0, 1'b0, "rst_clr");
        cmp("rst_clr.rdd", 32'(fif.rd_data_o), 32'd0);

        // Wrap: level 8, 40 cycles of simultaneous rd+wr with counting data
        for (int k = 0; k < 8; k++) apply(1'b0, 1'b0, 1'b1, 16'(16'h0100 + k), 1'b0, "wrap_fill");
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, 1'b0, 1'b1, 16'(16'h0108 + i), 1'b1, "wrap");
            cmp("wrap.lvl", 32'(fif.level_o),   32'd8);
            cmp("wrap.seq", 32'(fif.rd_data_o), 32'(16'h0100 + i));
        end

        // Random traffic, write/read bias varying by epoch to visit full and empty
        for (int i = 0; i < 3000; i++) begin
            int unsigned wp;
            logic rst, clr, wr, rd;
            wp  = ((i / 200) % 2 == 0) ? 70 : 30;
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 149) == 0);
            wr  = ($urandom_range(0, 99) < wp);
            rd  = ($urandom_range(0, 99) < (100 - wp));
            apply(rst, clr, wr, 16'($urandom), rd, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
